// File: rtl/irda_mir_pkg.sv
// Shared MIR definitions: stuffing limit, flag/abort patterns and the
// bit stuffer/destuffer state encoding.
package irda_mir_pkg;

    // Consecutive data ones after which a zero is inserted.
    localparam int MIR_ONES_LIMIT = 5;

    // Byte width carried across the framer/stuffer interface.
    localparam int MIR_DATA_W = 8;

    // Opening/closing flag, sent without stuffing.
    localparam logic [7:0] MIR_FLAG = 8'h7E;

    // Abort pattern: seven consecutive ones, illegal in stuffed data.
    localparam logic [7:0] MIR_ABORT = 8'h7F;

    // Stuffer/destuffer sequencing states.
    typedef enum logic [1:0] {
        MIR_BS_IDLE  = 2'b00,
        MIR_BS_SHIFT = 2'b01,
        MIR_BS_STUFF = 2'b10
    } mir_bs_state_e;

endpackage : irda_mir_pkg

// File: rtl/irda_mir_bit_stuffer.sv
// MIR transmit bit stuffer: takes bytes over valid/ready, shifts them out
// LSB first one bit per mir_txbit_enable, and inserts a 0 after every
// ONES_LIMIT consecutive data ones. Flag bytes go out unstuffed and clear
// the ones run.
module irda_mir_bit_stuffer
    import irda_mir_pkg::*;
#(
    parameter int ONES_LIMIT = MIR_ONES_LIMIT,
    parameter int DATA_W     = MIR_DATA_W
) (
    input  logic              clk,
    input  logic              wb_rst_n_i,
    input  logic              bs_restart,
    input  logic              mir_txbit_enable,
    input  logic [DATA_W-1:0] bs_data_i,
    input  logic              bs_flag_i,
    input  logic              bs_valid_i,
    output logic              bs_ready_o,
    output logic              bs_o,
    output logic              bs_bit_valid_o,
    output logic              bs_is_stuff_bit,
    output logic              bs_busy_o
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int ONES_W = $clog2(ONES_LIMIT + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(ONES_LIMIT);
    localparam logic [ONES_W-1:0] ONES_ZERO = {ONES_W{1'b0}};
    localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);

    // Holding register (filled by the handshake)
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_flag;
    logic              r_hold_full;

    // Shift register and sequencing state
    logic [DATA_W-1:0] r_shift_data;
    logic              r_shift_flag;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ONES_W-1:0] r_ones_cnt;
    mir_bs_state_e     r_state;

    // Registered serial outputs
    logic r_bit;
    logic r_bit_valid;
    logic r_stuff;

    logic              w_accept;
    logic              w_load;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic [ONES_W-1:0] w_ones_next;

    // Handshake, shift-load condition and next ones-run value for a shifted bit.
    always_comb begin
        w_accept    = bs_valid_i & ~r_hold_full;
        w_load      = r_hold_full & (r_bit_cnt == CNT_ZERO) & (r_state != MIR_BS_STUFF);
        w_cnt_dec   = r_bit_cnt - CNT_ONE;
        w_ones_next = ONES_ZERO;
        if (r_shift_flag) begin
            w_ones_next = ONES_ZERO;
        end else if (r_shift_data[0]) begin
            // Below ONES_MAX whenever a bit is shifted, so this cannot wrap.
            w_ones_next = r_ones_cnt + ONES_ONE;
        end else begin
            w_ones_next = ONES_ZERO;
        end
    end

    // Holding register: filled on accept, emptied when moved into the shifter.
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_hold_data <= {DATA_W{1'b0}};
            r_hold_flag <= 1'b0;
            r_hold_full <= 1'b0;
        end else if (bs_restart) begin
            r_hold_data <= {DATA_W{1'b0}};
            r_hold_flag <= 1'b0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_data <= bs_data_i;
            r_hold_flag <= bs_flag_i;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else begin
            r_hold_full <= r_hold_full;
        end
    end

    // Shifter, ones-run counter, state machine and registered serial outputs.
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_shift_data <= {DATA_W{1'b0}};
            r_shift_flag <= 1'b0;
            r_bit_cnt    <= CNT_ZERO;
            r_ones_cnt   <= ONES_ZERO;
            r_state      <= MIR_BS_IDLE;
            r_bit        <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_stuff      <= 1'b0;
        end else if (bs_restart) begin
            r_shift_data <= {DATA_W{1'b0}};
            r_shift_flag <= 1'b0;
            r_bit_cnt    <= CNT_ZERO;
            r_ones_cnt   <= ONES_ZERO;
            r_state      <= MIR_BS_IDLE;
            r_bit        <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_stuff      <= 1'b0;
        end else begin
            // Load only happens with an empty shifter, so it never collides with a shift.
            if (w_load) begin
                r_shift_data <= r_hold_data;
                r_shift_flag <= r_hold_flag;
                r_bit_cnt    <= CNT_FULL;
            end

            if (mir_txbit_enable) begin
                case (r_state)
                    MIR_BS_STUFF: begin
                        // Owed stuff zero goes out before anything else, shifter untouched.
                        r_bit       <= 1'b0;
                        r_bit_valid <= 1'b1;
                        r_stuff     <= 1'b1;
                        r_ones_cnt  <= ONES_ZERO;
                        if ((r_bit_cnt != CNT_ZERO) || r_hold_full) begin
                            r_state <= MIR_BS_SHIFT;
                        end else begin
                            r_state <= MIR_BS_IDLE;
                        end
                    end
                    MIR_BS_SHIFT, MIR_BS_IDLE: begin
                        if (r_bit_cnt != CNT_ZERO) begin
                            r_bit        <= r_shift_data[0];
                            r_bit_valid  <= 1'b1;
                            r_stuff      <= 1'b0;
                            r_shift_data <= r_shift_data >> 1;
                            r_bit_cnt    <= w_cnt_dec;
                            r_ones_cnt   <= w_ones_next;
                            if (w_ones_next == ONES_MAX) begin
                                r_state <= MIR_BS_STUFF;
                            end else if ((w_cnt_dec != CNT_ZERO) || r_hold_full) begin
                                r_state <= MIR_BS_SHIFT;
                            end else begin
                                r_state <= MIR_BS_IDLE;
                            end
                        end else begin
                            // Nothing in the shifter this period (idle or underrun);
                            // the ones run is kept for when data resumes.
                            r_bit       <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_stuff     <= 1'b0;
                            if (w_load) begin
                                r_state <= MIR_BS_SHIFT;
                            end else begin
                                r_state <= MIR_BS_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_bit       <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_stuff     <= 1'b0;
                        r_state     <= MIR_BS_IDLE;
                    end
                endcase
            end else if (w_load) begin
                r_state <= MIR_BS_SHIFT;
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bs_ready_o      = ~r_hold_full;
    assign bs_o            = r_bit;
    assign bs_bit_valid_o  = r_bit_valid;
    assign bs_is_stuff_bit = r_stuff;
    assign bs_busy_o       = r_hold_full | (r_bit_cnt != CNT_ZERO) | (r_state == MIR_BS_STUFF);

endmodule : irda_mir_bit_stuffer
